// File: rtl/bus_target_mem.sv
// Responder end of the addr/valid/data/wen/ren/ready request bus, backed by a
// local DEPTH x 64-bit memory with a fixed number of wait states per request.
module bus_target_mem #(
    parameter int          VALID_W     = 3,
    parameter int          DEPTH       = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        addr,
    input  logic [VALID_W-1:0] valid,
    input  logic [63:0]        data,
    input  logic               wen,
    input  logic               ren,
    output logic               ready,
    output logic [63:0]        rdata,
    output logic               rvalid,
    output logic [VALID_W-1:0] rtag,
    output logic               err
);

    // state  | meaning
    // S_IDLE | waiting for valid != 0; captures the request and decodes errors
    // S_WAIT | counting down the wait states
    // S_RESP | single ready cycle; a good write commits on the closing edge
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [32:0] SPAN      = 33'(DEPTH) << 3;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [VALID_W-1:0]  tag_q, tag_d;
    logic [63:0]         data_q, data_d;
    logic                wen_q, wen_d;
    logic                ren_q, ren_d;
    logic                err_q, err_d;

    logic [63:0]         mem [DEPTH];
    logic [63:0]         rd_q;

    logic [31:0]         off;
    logic [AW-1:0]       idx_in;
    logic                err_in;

    always_comb begin
        off    = addr - BASE_ADDR;
        idx_in = off[AW+2:3];
        err_in = (addr < BASE_ADDR) || ({1'b0, off} >= SPAN) ||
                 (addr[2:0] != 3'b000) || (wen == ren);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        tag_d   = tag_q;
        data_d  = data_q;
        wen_d   = wen_q;
        ren_d   = ren_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (valid != '0) begin
                    idx_d   = idx_in;
                    tag_d   = valid;
                    data_d  = data;
                    wen_d   = wen;
                    ren_d   = ren;
                    err_d   = err_in;
                    cnt_d   = WAIT_LOAD;
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            tag_q   <= '0;
            data_q  <= '0;
            wen_q   <= 1'b0;
            ren_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            wen_q   <= wen_d;
            ren_q   <= ren_d;
            err_q   <= err_d;
        end
    end

    // Read port follows the incoming index while idle so a zero-wait build
    // still has the word ready in the response cycle.
    always_ff @(posedge clk) begin
        rd_q <= mem[(state_q == S_IDLE) ? idx_in : idx_q];
    end

    always_ff @(posedge clk) begin
        if (!reset && state_q == S_RESP && wen_q && !err_q) begin
            mem[idx_q] <= data_q;
        end
    end

    always_comb begin
        ready  = (state_q == S_RESP);
        err    = ready && err_q;
        rvalid = ready && ren_q && !err_q;
        rdata  = rvalid ? rd_q : 64'd0;
        rtag   = ready ? tag_q : '0;
    end

endmodule

// File: tb/tb_bus_target_mem.sv
// Scoreboard bench for bus_target_mem: a 2-wait-state build (index 0) and a
// zero-wait 16-word build (index 1) share clock and reset.
module tb_bus_target_mem;

    localparam int W0 = 2;
    localparam int W1 = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr_s   [2];
    logic [2:0]  valid_s  [2];
    logic [63:0] data_s   [2];
    logic        wen_s    [2];
    logic        ren_s    [2];
    logic        ready_s  [2];
    logic [63:0] rdata_s  [2];
    logic        rvalid_s [2];
    logic [2:0]  rtag_s   [2];
    logic        err_s    [2];

    always #5 clk = ~clk;

    bus_target_mem #(.VALID_W(3), .DEPTH(256), .WAIT_CYCLES(W0), .BASE_ADDR(32'h0)) u_dut0 (
        .clk(clk), .reset(reset), .addr(addr_s[0]), .valid(valid_s[0]), .data(data_s[0]),
        .wen(wen_s[0]), .ren(ren_s[0]), .ready(ready_s[0]), .rdata(rdata_s[0]),
        .rvalid(rvalid_s[0]), .rtag(rtag_s[0]), .err(err_s[0])
    );

    bus_target_mem #(.VALID_W(3), .DEPTH(16), .WAIT_CYCLES(W1), .BASE_ADDR(32'h0)) u_dut1 (
        .clk(clk), .reset(reset), .addr(addr_s[1]), .valid(valid_s[1]), .data(data_s[1]),
        .wen(wen_s[1]), .ren(ren_s[1]), .ready(ready_s[1]), .rdata(rdata_s[1]),
        .rvalid(rvalid_s[1]), .rtag(rtag_s[1]), .err(err_s[1])
    );

    typedef struct packed {
        int          cyc;
        logic [2:0]  tag;
        logic        err;
        logic        rv;
        logic [63:0] rd;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    logic prev_rdy [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic mon(input int d);
        exp_t e;
        bit   have;
        if (ready_s[d]) begin
            checks++;
            if (prev_rdy[d]) begin
                errors++;
                $display("FAIL ready_width dut%0d: ready high two cycles in a row at cyc %0d", d, cyc);
            end
            have = (d == 0) ? (sb0.size() != 0) : (sb1.size() != 0);
            if (!have) begin
                checks++; errors++;
                $display("FAIL unexpected_ready dut%0d: ready at cyc %0d with nothing expected", d, cyc);
            end else begin
                if (d == 0) e = sb0.pop_front();
                else        e = sb1.pop_front();
                checks += 5;
                if (cyc != e.cyc) begin
                    errors++; $display("FAIL latency dut%0d: got cyc %0d want %0d", d, cyc, e.cyc);
                end
                if (rtag_s[d] != e.tag) begin
                    errors++; $display("FAIL rtag dut%0d: got %0d want %0d", d, rtag_s[d], e.tag);
                end
                if (err_s[d] != e.err) begin
                    errors++; $display("FAIL err dut%0d tag%0d: got %0b want %0b", d, e.tag, err_s[d], e.err);
                end
                if (rvalid_s[d] != e.rv) begin
                    errors++; $display("FAIL rvalid dut%0d tag%0d: got %0b want %0b", d, e.tag, rvalid_s[d], e.rv);
                end
                if (rdata_s[d] !== e.rd) begin
                    errors++; $display("FAIL rdata dut%0d tag%0d: got %h want %h", d, e.tag, rdata_s[d], e.rd);
                end
            end
        end else begin
            checks++;
            if (rtag_s[d] !== 3'd0 || err_s[d] !== 1'b0 || rvalid_s[d] !== 1'b0 || rdata_s[d] !== 64'd0) begin
                errors++;
                $display("FAIL idle_outputs dut%0d cyc %0d: rtag=%0d err=%0b rvalid=%0b rdata=%h want all 0",
                         d, cyc, rtag_s[d], err_s[d], rvalid_s[d], rdata_s[d]);
            end
        end
        prev_rdy[d] = ready_s[d];
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // Call just after a rising edge; returns the cycle ready was seen.
    task automatic req(input int d, input logic [31:0] a, input logic [63:0] dt,
                       input logic w, input logic r, input logic [2:0] tg,
                       input logic ee, input logic erv, input logic [63:0] erd,
                       output int rc);
        exp_t e;
        addr_s[d]  = a;
        data_s[d]  = dt;
        wen_s[d]   = w;
        ren_s[d]   = r;
        valid_s[d] = tg;
        e.cyc = cyc + ((d == 0) ? W0 : W1) + 1;
        e.tag = tg;
        e.err = ee;
        e.rv  = erv;
        e.rd  = erd;
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
        rc = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ready_s[d]) begin
                rc = cyc;
                break;
            end
        end
        if (rc < 0) begin
            checks++; errors++;
            $display("FAIL timeout dut%0d tag%0d: no ready within 40 cycles, want ready", d, tg);
        end
        @(posedge clk); #1;
        valid_s[d] = '0;
        wen_s[d]   = 1'b0;
        ren_s[d]   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r1, r2, rx;
        prev_rdy[0] = 1'b0;
        prev_rdy[1] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            addr_s[d] = '0; valid_s[d] = '0; data_s[d] = '0; wen_s[d] = 1'b0; ren_s[d] = 1'b0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Basic write / read
        req(0, 32'h10, 64'hDEADBEEF_01234567, 1, 0, 3'd5, 0, 0, 64'd0, rx);
        req(0, 32'h10, 64'd0, 0, 1, 3'd2, 0, 1, 64'hDEADBEEF_01234567, rx);
        req(0, 32'h18, 64'h1111_2222_3333_4444, 1, 0, 3'd1, 0, 0, 64'd0, rx);

        // Error cases
        req(0, 32'h13, 64'd0, 0, 1, 3'd3, 1, 0, 64'd0, rx);
        req(0, 32'h800, 64'd0, 0, 1, 3'd4, 1, 0, 64'd0, rx);
        req(0, 32'h18, 64'h0BAD, 1, 1, 3'd6, 1, 0, 64'd0, rx);
        req(0, 32'h18, 64'h0BAD, 0, 0, 3'd7, 1, 0, 64'd0, rx);
        req(0, 32'h18, 64'd0, 0, 1, 3'd1, 0, 1, 64'h1111_2222_3333_4444, rx);
        req(0, 32'h7F8, 64'h7777_0000_0000_0001, 1, 0, 3'd2, 0, 0, 64'd0, rx);
        req(0, 32'h7F8, 64'd0, 0, 1, 3'd3, 0, 1, 64'h7777_0000_0000_0001, rx);

        // Back-to-back writes, valid never dropped between them
        req(0, 32'h0, 64'hA0A0_A0A0_A0A0_A0A0, 1, 0, 3'd1, 0, 0, 64'd0, r1);
        req(0, 32'h8, 64'hA8A8_A8A8_A8A8_A8A8, 1, 0, 3'd2, 0, 0, 64'd0, r2);
        checks++;
        if (r2 - r1 != W0 + 2) begin
            errors++;
            $display("FAIL back_to_back_spacing: got %0d cycles want %0d", r2 - r1, W0 + 2);
        end
        req(0, 32'h0, 64'd0, 0, 1, 3'd3, 0, 1, 64'hA0A0_A0A0_A0A0_A0A0, rx);
        req(0, 32'h8, 64'd0, 0, 1, 3'd4, 0, 1, 64'hA8A8_A8A8_A8A8_A8A8, rx);

        // Reset during WAIT aborts an uncommitted write
        req(0, 32'h28, 64'h5555_5555_5555_5555, 1, 0, 3'd3, 0, 0, 64'd0, rx);
        addr_s[0] = 32'h28; data_s[0] = 64'h9999_9999_9999_9999;
        wen_s[0] = 1'b1; ren_s[0] = 1'b0; valid_s[0] = 3'd4;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        valid_s[0] = '0; wen_s[0] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        req(0, 32'h28, 64'd0, 0, 1, 3'd5, 0, 1, 64'h5555_5555_5555_5555, rx);

        // Zero-wait build
        req(1, 32'h20, 64'hCAFE_F00D_1234_5678, 1, 0, 3'd1, 0, 0, 64'd0, rx);
        req(1, 32'h20, 64'd0, 0, 1, 3'd6, 0, 1, 64'hCAFE_F00D_1234_5678, rx);
        req(1, 32'h78, 64'h0F0F_0F0F_0F0F_0F0F, 1, 0, 3'd2, 0, 0, 64'd0, rx);
        req(1, 32'h78, 64'd0, 0, 1, 3'd7, 0, 1, 64'h0F0F_0F0F_0F0F_0F0F, rx);
        req(1, 32'h80, 64'd0, 0, 1, 3'd3, 1, 0, 64'd0, rx);

        repeat (4) @(negedge clk);
        checks++;
        if (sb0.size() != 0 || sb1.size() != 0) begin
            errors++;
            $display("FAIL pending_responses: got %0d/%0d outstanding want 0/0", sb0.size(), sb1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
